// File: rtl/idelay_group_pkg.sv
// idelay_group_pkg: shared definitions for the delay-tap group controller.
//   - state_e        : controller FSM states (ST_VERIFY exists only when
//                      IDELAY_GROUP_VERIFY_EN is defined)
//   - CTRL_*_BIT     : bit positions inside the CTRL register
//   - STATUS_*       : bit positions inside the STATUS register
//   - *_addr helpers : register offsets as a function of the channel count
package idelay_group_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3
`ifdef IDELAY_GROUP_VERIFY_EN
        , ST_VERIFY = 3'd4
`endif
    } state_e;

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_FORCE_BIT   = 1;
    localparam int CTRL_CLEAR_BIT   = 2;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_ERROR_BIT = 1;
    localparam int STATUS_FAIL_LSB  = 2;

    // First address past the shadow tap block
    function automatic int shadow_end_addr(input int channels);
        return channels;
    endfunction

    function automatic int ctrl_addr(input int channels);
        return channels;
    endfunction

    function automatic int status_addr(input int channels);
        return channels + 1;
    endfunction

endpackage

// File: rtl/lowest_set_index.sv
// lowest_set_index: priority encoder returning the lowest set bit of vec.
//   vec   in  WIDTH   request vector
//   idx   out IDX_W   index of the lowest set bit (0 when none set)
//   valid out 1       at least one bit of vec is set
module lowest_set_index #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx_s;
    logic             valid_s;

    // Scan from the top down so the lowest set bit is the last one kept
    always_comb begin
        idx_s   = '0;
        valid_s = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_s   = IDX_W'(i);
                valid_s = 1'b1;
            end else begin
                valid_s = valid_s;
            end
        end
    end

    assign idx   = idx_s;
    assign valid = valid_s;

endmodule

// File: rtl/idelay_group_ctrl.sv
// idelay_group_ctrl: shadow-register front end for a bank of delay cells.
// Holds one tap value per channel; a commit walks the dirty channels in
// ascending order, strobing each cell once and waiting (bounded by TIMEOUT)
// for its done pulse.
// Optional feature: define IDELAY_GROUP_VERIFY_EN to add a VERIFY state that
// compares the cell readback with the shadow value after each load.
// Ports:
//   NATIVE_CLK, rst_n                 clock, async active-low reset
//   NATIVE_EN/WR/ADDR/DATA_IN         register request
//   NATIVE_DATA_OUT, NATIVE_READY     registered response (1 cycle later)
//   dly_load, dly_value               one-hot load strobe and shared value
//   dly_done, dly_readback            per-cell completion and current taps
//   busy, error                       sequence active, sticky failure
module idelay_group_ctrl
    import idelay_group_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int TAP_WIDTH  = 9,
    parameter int TIMEOUT    = 255,
    parameter int ADDR_WIDTH = $clog2(CHANNELS + 2)
) (
    input  logic                          NATIVE_CLK,
    input  logic                          rst_n,
    input  logic                          NATIVE_EN,
    input  logic                          NATIVE_WR,
    input  logic [ADDR_WIDTH-1:0]         NATIVE_ADDR,
    input  logic [TAP_WIDTH-1:0]          NATIVE_DATA_IN,
    output logic [TAP_WIDTH-1:0]          NATIVE_DATA_OUT,
    output logic                          NATIVE_READY,
    output logic [CHANNELS-1:0]           dly_load,
    output logic [TAP_WIDTH-1:0]          dly_value,
    input  logic [CHANNELS-1:0]           dly_done,
    input  logic [CHANNELS*TAP_WIDTH-1:0] dly_readback,
    output logic                          busy,
    output logic                          error
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SHADOW_END  = ADDR_WIDTH'(shadow_end_addr(CHANNELS));
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(ctrl_addr(CHANNELS));
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(status_addr(CHANNELS));
    localparam logic [CHANNELS-1:0]   ONE_LSB     = CHANNELS'(1'b1);
    localparam logic [15:0]           TMO_LIMIT   = 16'(TIMEOUT);

    state_e                 state_r, next_state_s;
    logic [IDX_W-1:0]       ch_r;
    logic [15:0]            cnt_r;
    logic [TAP_WIDTH-1:0]   shadow_r [CHANNELS];
    logic [CHANNELS-1:0]    dirty_r;
    logic [CHANNELS-1:0]    fail_r;
    logic                   error_r;
    logic                   busy_r;
    logic                   ready_r;
    logic [TAP_WIDTH-1:0]   data_out_r;
    logic [CHANNELS-1:0]    dly_load_r;
    logic [TAP_WIDTH-1:0]   dly_value_r;

    logic                   is_shadow_s;
    logic                   wr_shadow_s;
    logic                   wr_ctrl_s;
    logic                   commit_s;
    logic                   force_s;
    logic                   clear_s;
    logic [IDX_W-1:0]       addr_idx_s;
    logic [IDX_W-1:0]       enc_idx_s;
    logic                   enc_valid_s;
    logic [TAP_WIDTH-1:0]   status_s;
    logic [TAP_WIDTH-1:0]   rd_data_s;
    logic [TAP_WIDTH-1:0]   load_val_s;
    logic                   fail_set_s;
    logic [CHANNELS-1:0]    set_mask_s;
    logic [CHANNELS-1:0]    clr_mask_s;

`ifdef IDELAY_GROUP_VERIFY_EN
    logic [TAP_WIDTH-1:0]   rb_val_s;
    assign rb_val_s = dly_readback[ch_r*TAP_WIDTH +: TAP_WIDTH];
`else
    logic                   unused_readback_s;
    assign unused_readback_s = ^dly_readback;
`endif

    assign is_shadow_s = (NATIVE_ADDR < SHADOW_END);
    assign addr_idx_s  = NATIVE_ADDR[IDX_W-1:0];
    assign wr_shadow_s = NATIVE_EN & NATIVE_WR & is_shadow_s;
    assign wr_ctrl_s   = NATIVE_EN & NATIVE_WR & (NATIVE_ADDR == CTRL_ADDR);
    assign force_s     = wr_ctrl_s & NATIVE_DATA_IN[CTRL_FORCE_BIT];
    assign commit_s    = wr_ctrl_s & (NATIVE_DATA_IN[CTRL_COMMIT_BIT] | NATIVE_DATA_IN[CTRL_FORCE_BIT]);
    assign clear_s     = wr_ctrl_s & NATIVE_DATA_IN[CTRL_CLEAR_BIT];
    // {fail_mask, error, busy}; fail bits beyond the data width are dropped
    assign status_s    = TAP_WIDTH'({fail_r, error_r, busy_r});

    lowest_set_index #(
        .WIDTH (CHANNELS),
        .IDX_W (IDX_W)
    ) u_scan (
        .vec   (dirty_r),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // Read data mux: shadows, STATUS, zero for CTRL and unmapped addresses
    always_comb begin
        rd_data_s = '0;
        if (is_shadow_s) begin
            rd_data_s = shadow_r[addr_idx_s];
        end else if (NATIVE_ADDR == STATUS_ADDR) begin
            rd_data_s = status_s;
        end else begin
            rd_data_s = '0;
        end
    end

    // Load value with bypass, so a same-cycle write to the picked channel is not lost
    always_comb begin
        load_val_s = shadow_r[enc_idx_s];
        if (wr_shadow_s && (addr_idx_s == enc_idx_s)) begin
            load_val_s = NATIVE_DATA_IN;
        end else begin
            load_val_s = shadow_r[enc_idx_s];
        end
    end

    // Next-state logic and per-channel failure detection
    always_comb begin
        next_state_s = state_r;
        fail_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (commit_s) begin
                    next_state_s = ST_SCAN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (enc_valid_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // done on the timeout cycle still counts as success
                if (dly_done[ch_r]) begin
`ifdef IDELAY_GROUP_VERIFY_EN
                    next_state_s = ST_VERIFY;
`else
                    next_state_s = ST_SCAN;
`endif
                end else if (cnt_r == TMO_LIMIT) begin
                    next_state_s = ST_SCAN;
                    fail_set_s   = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
`ifdef IDELAY_GROUP_VERIFY_EN
            ST_VERIFY: begin
                next_state_s = ST_SCAN;
                if (rb_val_s != shadow_r[ch_r]) begin
                    fail_set_s = 1'b1;
                end else begin
                    fail_set_s = 1'b0;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Dirty mask updates: writes and force set bits, the LOAD cycle clears one
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (force_s) begin
            set_mask_s = '1;
        end else if (wr_shadow_s) begin
            set_mask_s = ONE_LSB << addr_idx_s;
        end else begin
            set_mask_s = '0;
        end
        if (state_r == ST_LOAD) begin
            clr_mask_s = ONE_LSB << ch_r;
        end else begin
            clr_mask_s = '0;
        end
    end

    // FSM state register
    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Active channel capture and WAIT timeout counter
    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            ch_r  <= '0;
            cnt_r <= 16'd0;
        end else begin
            if (state_r == ST_SCAN && enc_valid_s) begin
                ch_r <= enc_idx_s;
            end
            if (state_r == ST_WAIT && next_state_s == ST_WAIT) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= 16'd0;
            end
        end
    end

    // Shadow tap storage and dirty mask; a set in the LOAD cycle beats the clear
    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= '0;
            end
            dirty_r <= '0;
        end else begin
            if (wr_shadow_s) begin
                shadow_r[addr_idx_s] <= NATIVE_DATA_IN;
            end
            dirty_r <= (dirty_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Sticky error and fail mask; clear is applied before a same-cycle failure
    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            fail_r  <= '0;
            error_r <= 1'b0;
        end else if (fail_set_s) begin
            fail_r  <= (clear_s ? '0 : fail_r) | (ONE_LSB << ch_r);
            error_r <= 1'b1;
        end else if (clear_s) begin
            fail_r  <= '0;
            error_r <= 1'b0;
        end else begin
            fail_r  <= fail_r;
            error_r <= error_r;
        end
    end

    // Registered outputs: register response, busy and the cell load strobe
    always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b0;
            data_out_r  <= '0;
            busy_r      <= 1'b0;
            dly_load_r  <= '0;
            dly_value_r <= '0;
        end else begin
            ready_r    <= NATIVE_EN;
            data_out_r <= (NATIVE_EN && !NATIVE_WR) ? rd_data_s : '0;
            busy_r     <= (next_state_s != ST_IDLE);
            if (state_r == ST_SCAN && enc_valid_s) begin
                dly_load_r  <= ONE_LSB << enc_idx_s;
                dly_value_r <= load_val_s;
            end else begin
                dly_load_r  <= '0;
                dly_value_r <= '0;
            end
        end
    end

    assign NATIVE_READY    = ready_r;
    assign NATIVE_DATA_OUT = data_out_r;
    assign dly_load        = dly_load_r;
    assign dly_value       = dly_value_r;
    assign busy            = busy_r;
    assign error           = error_r;

endmodule

// File: doc/idelay_group_ctrl.md
# idelay_group_ctrl

Multi-channel delay-tap controller that sits between the native register port and a bank of IDELAY3_DRP-style delay cells. It holds one shadow tap value per channel and, on a commit command, loads only the changed channels into their cells, one at a time. Each load waits for the cell's done handshake and is bounded by a timeout. Channel count, tap width and timeout are parameters, and an optional readback-verify stage is available.

## Interface
- CHANNELS, 8: number of delay cells driven; 1..32.
- TAP_WIDTH, 9: tap/delay value width; minimum 4.
- TIMEOUT, 255: maximum WAIT cycles per channel load; 1..65535.
- ADDR_WIDTH, $clog2(CHANNELS+2): derived; not overridden.
- NATIVE_CLK  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- NATIVE_EN  in  1  request strobe, one request per asserted cycle.
- NATIVE_WR  in  1  1 = write, 0 = read.
- NATIVE_ADDR  in  ADDR_WIDTH  register address.
- NATIVE_DATA_IN  in  TAP_WIDTH  write data.
- NATIVE_DATA_OUT  out  TAP_WIDTH  read data; valid while NATIVE_READY = 1.
- NATIVE_READY  out  1  one-cycle completion pulse per request.
- dly_load  out  CHANNELS  one-hot, one-cycle load strobe to a cell.
- dly_value  out  TAP_WIDTH  shared value bus; valid while any dly_load bit is 1.
- dly_done  in  CHANNELS  per-cell load-complete pulse.
- dly_readback  in  CHANNELS*TAP_WIDTH  current tap of each cell; channel k occupies bits [k*TAP_WIDTH +: TAP_WIDTH].
- busy  out  1  commit sequence in progress.
- error  out  1  sticky timeout or verify failure.

## Operation
- Register map:
  - addresses 0..CHANNELS-1: shadow taps, read/write.
  - CHANNELS: CTRL, write-only; reads 0.
    - bit0 commit: start loading dirty channels.
    - bit1 force: mark all channels dirty, then commit.
    - bit2 clear: clear error and fail_mask.
  - CHANNELS+1: STATUS, read-only; {fail_mask low bits, error, busy} from LSB upward.
- Out-of-range address: write ignored, read returns 0, READY still pulses.
- A shadow write stores the value and sets that channel's dirty bit, including while busy.
- FSM states IDLE, SCAN, LOAD, WAIT, plus VERIFY when verify is compiled in.
  - IDLE: on commit or force, go to SCAN.
  - SCAN: pick the lowest-index dirty channel. If the dirty mask is zero, go to IDLE.
  - LOAD: pulse dly_load[ch], drive dly_value = shadow[ch], clear dirty[ch], go to WAIT.
  - WAIT: on dly_done[ch], go to VERIFY or SCAN.
  - WAIT timeout (counter reaches TIMEOUT): set error and fail_mask[ch], go to SCAN. The channel is not retried.
- A write to channel ch during its own WAIT re-sets dirty[ch], so ch is reloaded within the same sequence.
- A commit while busy has no extra effect. The running sequence drains all dirty bits.
- dly_done bits for channels other than the one in WAIT are ignored.
- Clear and commit in the same write: clear is applied first.

## Timing
- Reset values: NATIVE_READY 0, NATIVE_DATA_OUT 0, dly_load 0, dly_value 0, busy 0, error 0. All shadows, dirty bits and fail_mask are 0.
- Register access: NATIVE_READY and read data are registered and appear exactly 1 cycle after NATIVE_EN. Throughput is 1 request per cycle.
- Commit write at cycle T:
  - SCAN in T+1, with busy = 1 from T+1.
  - dly_load in T+2.
  - WAIT from T+3.
- Per channel: 3 cycles plus done latency (4 cycles with verify).
- busy falls in the cycle after SCAN finds the dirty mask empty.
- Timeout counter starts at 0 on WAIT entry. Timeout is flagged in the cycle the counter equals TIMEOUT.
- A dly_done arriving in the same cycle as the timeout counts as success.
- Reset asserted mid-sequence clears state immediately and asynchronously. dly_load never pulses for two cycles.

## Configuration
- IDELAY_GROUP_VERIFY_EN defined: after done, VERIFY waits 1 cycle, then compares dly_readback[ch] with shadow[ch]. On mismatch it sets error and fail_mask[ch].
- IDELAY_GROUP_VERIFY_EN undefined: no VERIFY state; WAIT goes directly to SCAN and dly_readback is unused.
- Both builds: reading STATUS reports fail_mask, which holds timeout failures in either build and verify failures only when the macro is defined.

## Structure
- Package idelay_group_pkg holds:
  - the FSM state enum;
  - CTRL bit positions (COMMIT, FORCE, CLEAR);
  - STATUS bit positions;
  - register offset helper functions of CHANNELS.
- Sub-module lowest_set_index: parametrised priority encoder of width CHANNELS, outputs index and a valid flag. It is used by SCAN.

## Test plan
- Write shadow[3] = 9'h05A, then commit: dly_load = 8'b0000_1000 with dly_value = 9'h05A at T+2. With done returned 2 cycles later, busy drops and error = 0.
- Write channels 1, 4 and 6, then commit: loads issue in order 1, 4, 6. Channels that were not written receive no dly_load pulse.
- Hold dly_done[2] low with TIMEOUT = 16: error = 1 and STATUS bit for channel 2 set, remaining dirty channels still loaded. A CLEAR write then returns error to 0.
- Write shadow[0] while channel 0 is in WAIT: a second load of channel 0 carries the new value before busy drops.
- Read address CHANNELS+5 and write CTRL with force: read returns 0 with READY after 1 cycle; all CHANNELS channels load in ascending order.
- Deassert rst_n during WAIT: all outputs are 0 immediately. After release, commit with no writes leaves busy low after 1 cycle and issues no loads. With IDELAY_GROUP_VERIFY_EN defined, a readback mismatch sets error.
